sobel_capture: RTL and testbench

Frame-capture sink for the Sobel filter output stream. It takes one pixel per valid cycle from the filter's `outputPixel` port and discards the pipeline-fill samples. It then writes exactly one IMG_WIDTH×IMG_HEIGHT frame into a word-addressed frame buffer, forcing the invalid border ring to zero. It sits between `sobel` and the result RAM and is the receive-side counterpart to the raster pixel driver that feeds the filter.

---
 rtl/sobel_capture.sv | 158 +++++++++++++++
 tb/tb_sobel_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_capture.sv
// sobel_capture: receive-side sink for the Sobel filter output stream.
// Drops the pipeline-fill samples that follow a start request, then writes
// exactly one IMG_WIDTH x IMG_HEIGHT frame into a word-addressed buffer.
// When ZERO_BORDER is set, the one-pixel border ring is written as zero,
// because the filter cannot produce valid results there.
module sobel_capture #(
    parameter int WORD_SIZE   = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int LATENCY     = 34,
    parameter int ZERO_BORDER = 1,
    localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] inputPixel,
    input  logic                 inValid,
    output logic                 wrEnable,
    output logic [ADDR_W-1:0]    wrAddr,
    output logic [WORD_SIZE-1:0] wrData,
    output logic                 busy,
    output logic                 frameDone
);

    localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int SKIP_W = (LATENCY    > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    // Unreachable when LATENCY is 0 (SKIP is bypassed), so clamp to 0 there.
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_start_accept;
    logic                 w_accept;
    logic                 w_border;
    logic                 w_zero;
    logic [WORD_SIZE-1:0] w_wr_data;

    logic [SKIP_W-1:0]    r_skip_cnt;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic [ADDR_W-1:0]    r_addr_cnt;

    // A start request only counts when the FSM is idle.
    assign w_start_accept = (r_state == ST_IDLE) && start;

    // Border ring: first/last row or first/last column of the frame.
    assign w_border = (r_row == '0) || (r_row == ROW_LAST) ||
                      (r_col == '0) || (r_col == COL_LAST);
    assign w_zero   = (ZERO_BORDER != 0) && w_border;

    // Per-bit masking of the pixel so border samples collapse to zero.
    generate
        for (genvar gi = 0; gi < WORD_SIZE; gi++) begin : g_data_mask
            assign w_wr_data[gi] = inputPixel[gi] & ~w_zero;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the per-cycle write-accept decision.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (LATENCY > 0) ? ST_SKIP : ST_CAPTURE;
                end
            end
            ST_SKIP: begin
                if (inValid && (r_skip_cnt == SKIP_LAST)) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (inValid) begin
                    w_accept = 1'b1;
                    if ((r_row == ROW_LAST) && (r_col == COL_LAST)) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Skip, raster position and linear address counters; cleared on each new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_skip_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_addr_cnt <= '0;
        end else if (w_start_accept) begin
            r_skip_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_addr_cnt <= '0;
        end else begin
            if ((r_state == ST_SKIP) && inValid) begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
            end
            if (w_accept) begin
                r_addr_cnt <= r_addr_cnt + 1'b1;
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Registered outputs; address and data hold between writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrEnable  <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            wrEnable  <= w_accept;
            if (w_accept) begin
                wrAddr <= r_addr_cnt;
                wrData <= w_wr_data;
            end
            busy      <= (w_state_next != ST_IDLE);
            frameDone <= (r_state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sobel_capture.sv
// tb_sobel_capture: directed bench for sobel_capture.
// Instance A: 4x4 frame, 3 fill samples, zeroed border.
// Instance B: 4x4 frame, no fill samples, raw data everywhere.
module tb_sobel_capture;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_start, a_valid;
    logic [7:0] a_pix;
    logic       a_wr_en, a_busy, a_done;
    logic [3:0] a_wr_addr;
    logic [7:0] a_wr_data;

    logic       b_start, b_valid;
    logic [7:0] b_pix;
    logic       b_wr_en, b_busy, b_done;
    logic [3:0] b_wr_addr;
    logic [7:0] b_wr_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int a_n, a_fd_cnt, a_fd_cyc;
    int b_n, b_fd_cnt, b_fd_cyc;
    int a_addr_log [32];
    int a_data_log [32];
    int b_addr_log [32];
    int b_data_log [32];

    always #5 clk = ~clk;

    sobel_capture #(
        .WORD_SIZE(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .LATENCY(3), .ZERO_BORDER(1)
    ) u_dut_a (
        .clock      (clk),
        .reset      (reset),
        .start      (a_start),
        .inputPixel (a_pix),
        .inValid    (a_valid),
        .wrEnable   (a_wr_en),
        .wrAddr     (a_wr_addr),
        .wrData     (a_wr_data),
        .busy       (a_busy),
        .frameDone  (a_done)
    );

    sobel_capture #(
        .WORD_SIZE(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .LATENCY(0), .ZERO_BORDER(0)
    ) u_dut_b (
        .clock      (clk),
        .reset      (reset),
        .start      (b_start),
        .inputPixel (b_pix),
        .inValid    (b_valid),
        .wrEnable   (b_wr_en),
        .wrAddr     (b_wr_addr),
        .wrData     (b_wr_data),
        .busy       (b_busy),
        .frameDone  (b_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs are already set; outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (a_wr_en === 1'b1) begin
            if (a_n < 32) begin
                a_addr_log[a_n] = int'(a_wr_addr);
                a_data_log[a_n] = int'(a_wr_data);
            end
            a_n++;
        end
        if (a_done === 1'b1) begin
            a_fd_cnt++;
            a_fd_cyc = cyc;
        end
        if (b_wr_en === 1'b1) begin
            if (b_n < 32) begin
                b_addr_log[b_n] = int'(b_wr_addr);
                b_data_log[b_n] = int'(b_wr_data);
            end
            b_n++;
        end
        if (b_done === 1'b1) begin
            b_fd_cnt++;
            b_fd_cyc = cyc;
        end
    endtask

    // Expected frame content for instance A: sample k+4 lands at address k,
    // border ring forced to zero.
    function automatic int exp_a(input int k);
        int row, col;
        row = k / 4;
        col = k % 4;
        if (row == 0 || row == 3 || col == 0 || col == 3) return 0;
        return k + 4;
    endfunction

    // Runs one frame on instance A, returning right after frameDone is seen.
    task automatic run_frame_a(input bit skip_gap, input bit cap_gap, input bit restart,
                               input int exp_lat, input string tag);
        int s_cyc;
        a_n = 0; a_fd_cnt = 0; a_fd_cyc = -1;
        a_start = 1'b1; a_valid = 1'b0; a_pix = 8'($urandom);
        step();
        s_cyc   = cyc;
        a_start = 1'b0;
        check({tag, "_busy_start"}, int'(a_busy), 1);
        for (int v = 1; v <= 19; v++) begin
            if (skip_gap && v == 2) begin
                for (int g = 0; g < 2; g++) begin
                    a_valid = 1'b0; a_pix = 8'($urandom);
                    step();
                    check({tag, "_skipgap_wren"}, int'(a_wr_en), 0);
                end
            end
            a_valid = 1'b1;
            a_pix   = 8'(v);
            a_start = restart && (v == 13);
            step();
            a_start = 1'b0;
            if (cap_gap && v == 10) begin
                for (int g = 0; g < 3; g++) begin
                    a_valid = 1'b0; a_pix = 8'($urandom);
                    step();
                    check({tag, "_capgap_wren"}, int'(a_wr_en), 0);
                end
            end
        end
        a_valid = 1'b0;
        for (int i = 0; i < 8 && a_fd_cnt == 0; i++) step();
        check({tag, "_done_cnt"}, a_fd_cnt, 1);
        check({tag, "_done_lat"}, a_fd_cyc - s_cyc, exp_lat);
        check({tag, "_busy_done"}, int'(a_busy), 0);
        check({tag, "_writes"}, a_n, 16);
        for (int k = 0; k < 16; k++) begin
            check({tag, "_addr"}, a_addr_log[k], k);
            check({tag, "_data"}, a_data_log[k], exp_a(k));
        end
        $display("frame %s: writes=%0d done_latency=%0d", tag, a_n, a_fd_cyc - s_cyc);
    endtask

    initial begin
        int s_cyc;
        reset   = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_pix = '0;
        b_start = 1'b0; b_valid = 1'b0; b_pix = '0;
        a_n = 0; a_fd_cnt = 0; a_fd_cyc = -1;
        b_n = 0; b_fd_cnt = 0; b_fd_cyc = -1;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            a_start = 1'($urandom_range(0, 1));
            a_valid = 1'($urandom_range(0, 1));
            a_pix   = 8'($urandom);
            b_start = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            b_pix   = 8'($urandom);
            step();
            check("rst_wren",  int'(a_wr_en),   0);
            check("rst_addr",  int'(a_wr_addr), 0);
            check("rst_data",  int'(a_wr_data), 0);
            check("rst_busy",  int'(a_busy),    0);
            check("rst_done",  int'(a_done),    0);
            check("rst_b_wren", int'(b_wr_en),  0);
            check("rst_b_busy", int'(b_busy),   0);
        end
        reset   = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_pix = 8'($urandom);
            step();
            check("idle_wren", int'(a_wr_en), 0);
            check("idle_busy", int'(a_busy),  0);
        end
        $display("reset: idle outputs observed");

        // Basic frame, stalled frame, ignored restart, then back-to-back frame.
        run_frame_a(1'b0, 1'b0, 1'b0, 20, "basic");
        run_frame_a(1'b1, 1'b1, 1'b0, 25, "stall");
        run_frame_a(1'b0, 1'b0, 1'b1, 20, "restart");
        run_frame_a(1'b0, 1'b0, 1'b0, 20, "b2b");

        // Mid-frame reset right after the address-7 write.
        a_n = 0;
        a_start = 1'b1; a_valid = 1'b0;
        step();
        a_start = 1'b0;
        for (int v = 1; v <= 11; v++) begin
            a_valid = 1'b1; a_pix = 8'(v);
            step();
        end
        check("mrst_pre_wren", int'(a_wr_en),   1);
        check("mrst_pre_addr", int'(a_wr_addr), 7);
        reset = 1'b1; a_pix = 8'd12;
        step();
        reset = 1'b0;
        check("mrst_wren", int'(a_wr_en),   0);
        check("mrst_busy", int'(a_busy),    0);
        check("mrst_addr", int'(a_wr_addr), 0);
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1; a_pix = 8'($urandom);
            step();
            check("mrst_idle_wren", int'(a_wr_en), 0);
        end
        $display("mid-frame reset: capture aborted");
        run_frame_a(1'b0, 1'b0, 1'b0, 20, "post_rst");

        // Raw mode with zero latency on instance B.
        a_valid = 1'b0;
        b_n = 0; b_fd_cnt = 0; b_fd_cyc = -1;
        b_start = 1'b1; b_valid = 1'b0;
        step();
        s_cyc   = cyc;
        b_start = 1'b0;
        check("raw_busy_start", int'(b_busy), 1);
        for (int v = 1; v <= 16; v++) begin
            b_valid = 1'b1; b_pix = 8'(v);
            step();
        end
        b_valid = 1'b0;
        for (int i = 0; i < 8 && b_fd_cnt == 0; i++) step();
        check("raw_done_cnt", b_fd_cnt, 1);
        check("raw_done_lat", b_fd_cyc - s_cyc, 17);
        check("raw_writes", b_n, 16);
        for (int k = 0; k < 16; k++) begin
            check("raw_addr", b_addr_log[k], k);
            check("raw_data", b_data_log[k], k + 1);
        end
        $display("frame raw: writes=%0d done_latency=%0d", b_n, b_fd_cyc - s_cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
